// File: rtl/sync_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_counter_pkg
// Description : Shared types for the counter snapshot/readout block: the
//               sequencer state encoding and the readout FIFO entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_counter_pkg;

    // Entry fields are stored at these widths; narrower counters are
    // zero-extended on write and truncated on read.
    localparam int c_COUNT_A_MAX_BITS = 64;
    localparam int c_COUNT_B_MAX_BITS = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ASSERT  = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        RELEASE = 3'd4
    } state_t;

    typedef struct packed {
        logic [c_COUNT_A_MAX_BITS-1:0] count_a;
        logic [c_COUNT_A_MAX_BITS-1:0] delta_a;
        logic [c_COUNT_B_MAX_BITS-1:0] count_b;
    } readout_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_counter_readout_fifo.sv
`default_nettype none
// ============================================================================
// Module      : readout_fifo
// Description : Small synchronous FIFO of readout entries. Registered write,
//               combinational head read. A push into a full FIFO is accepted
//               only when a pop happens in the same cycle. DEPTH is a power
//               of two, at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module readout_fifo
    import sync_counter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  readout_entry_t           i_data,
    input  logic                     i_pop,
    output readout_entry_t           o_head,
    output logic                     o_valid,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_PTR_W = $clog2(DEPTH);

    readout_entry_t       r_mem [DEPTH];
    logic [c_PTR_W:0]     r_wr_ptr;
    logic [c_PTR_W:0]     r_rd_ptr;
    logic                 w_wr_en;
    logic                 w_rd_en;

    // Extra pointer bit distinguishes full from empty.
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_valid = (o_level != '0);
    assign o_full  = (o_level == (c_PTR_W + 1)'(DEPTH));
    assign w_rd_en = i_pop && o_valid;
    assign w_wr_en = i_push && (!o_full || w_rd_en);
    assign o_head  = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    // Pointer updates for accepted pushes and pops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (c_PTR_W + 1)'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + (c_PTR_W + 1)'(1);
        end
    end

    // Storage is cleared on reset so the head fields read zero while empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sync_counter_readout.sv
`default_nettype none
// ============================================================================
// Module      : sync_counter_readout
// Description : Snapshot sequencer for an external counter block. On a
//               software trigger or auto-timer expiry it raises snapshot,
//               waits for the counter results to settle, captures them with
//               the wrap-safe delta of counter A and queues the entry.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_counter_readout
    import sync_counter_pkg::*;
#(
    parameter int COUNTER_A_BITS = 32,
    parameter int COUNTER_B_BITS = 11,
    parameter int SETTLE_CYCLES  = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          axi_clk,
    input  logic                          reset_n,
    input  logic                          trigger,
    input  logic [31:0]                   period,
    output logic                          snapshot,
    input  logic [COUNTER_A_BITS-1:0]     counter_a_result,
    input  logic [COUNTER_B_BITS-1:0]     counter_b_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COUNTER_A_BITS-1:0]     out_count_a,
    output logic [COUNTER_A_BITS-1:0]     out_delta_a,
    output logic [COUNTER_B_BITS-1:0]     out_count_b,
    output logic                          busy,
    output logic                          overflow,
    input  logic                          clear_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE_CYCLES - 1);

    state_t                     r_state;
    logic [c_SET_W-1:0]         r_settle_cnt;
    logic                       r_snapshot;
    logic [31:0]                r_timer;
    logic [31:0]                r_period_act;
    logic                       r_timer_fire;
    logic [COUNTER_A_BITS-1:0]  r_prev_a;
    logic                       r_overflow;

    logic                       w_start;
    logic [31:0]                w_period_eff;
    logic                       w_timer_hit;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_full;
    logic                       w_drop;
    logic [COUNTER_A_BITS-1:0]  w_delta_a;
    readout_entry_t             w_push_entry;
    readout_entry_t             w_head;

    // A new sequence starts only from IDLE; requests while busy are lost.
    assign w_start = (r_state == IDLE) && (trigger || r_timer_fire);

    // While the timer sits at zero it follows the live period; once counting
    // it uses the value latched at that zero point.
    assign w_period_eff = (r_timer == '0) ? period : r_period_act;
    assign w_timer_hit  = (r_state == IDLE) && (w_period_eff != '0) &&
                          (r_timer == w_period_eff - 32'd1);

    assign w_push    = (r_state == CAPTURE);
    assign w_pop     = out_valid && out_ready;
    assign w_drop    = w_push && w_full && !w_pop;
    assign w_delta_a = counter_a_result - r_prev_a;

    assign snapshot = r_snapshot;
    assign busy     = (r_state != IDLE);
    assign overflow = r_overflow;

    // Auto-trigger timer: counts only in IDLE, returns to zero on any exit.
    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer      <= '0;
            r_period_act <= '0;
            r_timer_fire <= 1'b0;
        end else begin
            // A trigger in the hit cycle already starts the sequence.
            r_timer_fire <= w_timer_hit && !w_start;
            if ((r_state != IDLE) || w_start || w_timer_hit) begin
                r_timer <= '0;
            end else if (w_period_eff != '0) begin
                r_timer <= r_timer + 32'd1;
            end
            if (r_timer == '0) r_period_act <= period;
        end
    end

    // Sequencer with registered snapshot, lagging the state by one cycle.
    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_settle_cnt <= '0;
            r_snapshot   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) r_state <= ASSERT;
                end
                ASSERT: begin
                    r_state      <= SETTLE;
                    r_settle_cnt <= '0;
                end
                SETTLE: begin
                    if (r_settle_cnt == c_SET_LAST) begin
                        r_state      <= CAPTURE;
                        r_settle_cnt <= '0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + c_SET_W'(1);
                    end
                end
                CAPTURE: begin
                    r_state      <= RELEASE;
                    r_settle_cnt <= '0;
                end
                RELEASE: begin
                    if (r_settle_cnt == c_SET_LAST) begin
                        r_state      <= IDLE;
                        r_settle_cnt <= '0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + c_SET_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
            r_snapshot <= (r_state == ASSERT) || (r_state == SETTLE) ||
                          (r_state == CAPTURE);
        end
    end

    // Previous counter A follows accepted captures; overflow is sticky and a
    // drop outranks a clear in the same cycle.
    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_a   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push && !w_drop) r_prev_a <= counter_a_result;
            if (w_drop)              r_overflow <= 1'b1;
            else if (clear_overflow) r_overflow <= 1'b0;
        end
    end

    // Pack the captured values into the shared entry layout.
    always_comb begin
        w_push_entry         = '0;
        w_push_entry.count_a = c_COUNT_A_MAX_BITS'(counter_a_result);
        w_push_entry.delta_a = c_COUNT_A_MAX_BITS'(w_delta_a);
        w_push_entry.count_b = c_COUNT_B_MAX_BITS'(counter_b_result);
    end

    readout_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (axi_clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (out_valid),
        .o_full  (w_full),
        .o_level (fifo_level)
    );

    assign out_count_a = COUNTER_A_BITS'(w_head.count_a);
    assign out_delta_a = COUNTER_A_BITS'(w_head.delta_a);
    assign out_count_b = COUNTER_B_BITS'(w_head.count_b);

endmodule
`default_nettype wire

// File: doc/sync_counter_readout.md
SYNC_COUNTER_READOUT -- requirements
Module: sync_counter_readout

Interface
REQ-001 SHALL have parameter COUNTER_A_BITS, default 32, width of counter A result.
REQ-002 SHALL have parameter COUNTER_B_BITS, default 11, width of counter B result.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 8, axi_clk cycles from snapshot rise to capture (covers tclk-domain CDC).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, power of two, result FIFO entries.
REQ-005 SHALL have port axi_clk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port trigger  input  1  one-cycle software request for a snapshot.
REQ-008 SHALL have port period  input  32  auto-trigger interval in axi_clk cycles; 0 = auto disabled.
REQ-009 SHALL have port snapshot  output  1  level to counter block; high freezes its results.
REQ-010 SHALL have port counter_a_result  input  COUNTER_A_BITS  counter A value from counter block.
REQ-011 SHALL have port counter_b_result  input  COUNTER_B_BITS  counter B value from counter block.
REQ-012 SHALL have ports out_valid output 1 / out_ready input 1, FIFO head handshake.
REQ-013 SHALL have ports out_count_a output COUNTER_A_BITS, out_delta_a output COUNTER_A_BITS, out_count_b output COUNTER_B_BITS: FIFO head fields.
REQ-014 SHALL have ports busy output 1 (FSM not IDLE), overflow output 1 (sticky), clear_overflow input 1, fifo_level output $clog2(FIFO_DEPTH)+1.

Function
REQ-015 FSM states SHALL be IDLE, ASSERT, SETTLE, CAPTURE, RELEASE.
REQ-016 IDLE -> ASSERT on trigger=1 or auto-timer expiry; snapshot SHALL go high the cycle after entering ASSERT and stay high through CAPTURE.
REQ-017 ASSERT -> SETTLE next cycle; SETTLE SHALL last exactly SETTLE_CYCLES cycles, then -> CAPTURE.
REQ-018 CAPTURE (one cycle) SHALL sample both result inputs, compute delta_a = count_a - prev_a modulo 2^COUNTER_A_BITS, update prev_a, push entry.
REQ-019 RELEASE SHALL hold snapshot low for SETTLE_CYCLES cycles, then -> IDLE.
REQ-020 First capture after reset SHALL report delta_a = count_a (prev_a reset 0).
REQ-021 Triggers while busy=1 SHALL be ignored (no queuing).
REQ-022 Auto timer SHALL count axi_clk cycles in IDLE only, fire when count reaches period-1, reload to 0 on any IDLE exit; period change takes effect on next reload.
REQ-023 trigger and timer expiry in the same cycle SHALL produce one snapshot.
REQ-024 Push with FIFO full SHALL drop the entry, set overflow, leave FIFO and prev_a unchanged.
REQ-025 overflow SHALL clear on clear_overflow=1 unless a drop occurs the same cycle (set wins).
REQ-026 out_valid SHALL equal FIFO non-empty; pop on out_valid & out_ready; head fields stable while out_valid & !out_ready.
REQ-027 Simultaneous push and pop with FIFO full SHALL accept the push (no overflow); fifo_level unchanged.
REQ-028 Data SHALL reach outputs one cycle after CAPTURE (registered FIFO write, combinational head read).

Reset
REQ-029 reset_n=0 SHALL immediately force FSM IDLE, snapshot 0, out_valid 0, fifo_level 0, overflow 0, busy 0, timer 0, prev_a 0, head fields 0.
REQ-030 Reset mid-sequence SHALL abandon the sequence with no FIFO push; operation resumes on first edge after reset_n deassertion.

Structure
REQ-031 Package sync_counter_pkg SHALL hold the FSM state enum and readout entry struct (count_a, delta_a, count_b).
REQ-032 FIFO SHALL be sub-module readout_fifo (synchronous, one clock, same reset).

Verification
REQ-033 Reset, trigger pulse at cycle 10 with count_a=100 -> snapshot high cycles 12..21, one entry count_a=100, delta_a=100.
REQ-034 Second trigger, count_a=0x0000_0005 after prev 0xFFFF_FFFE -> delta_a=7 (wrap).
REQ-035 period=50, out_ready=1 -> snapshot rises every 50+2*SETTLE_CYCLES+3 cycles; trigger during busy ignored.
REQ-036 out_ready=0, 5 triggers -> fifo_level=4, overflow=1, 5th dropped; clear_overflow -> 0; drain returns 4 in order.
REQ-037 reset_n low during SETTLE -> snapshot 0 same instant, fifo_level 0, no entry after release.
REQ-038 FIFO full, out_ready=1 during CAPTURE -> no overflow, level stays 4.
